// File: rtl/bc_pkg.sv
// Shared types and helpers for the bulls-and-cows engine.
// Contents: FSM state encoding, count-width helper function.
package bc_pkg;

  // 3-bit state encoding, also exported on out_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHK_S  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHK_G  = 3'd3,
    ST_CMP    = 3'd4,
    ST_RESULT = 3'd5,
    ST_WIN    = 3'd6,
    ST_LOSE   = 3'd7
  } state_t;

  // Bits needed to hold counts 0..n (at least 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bc_digit_check.sv
// Combinational code validator: every digit < BASE and all digits pairwise distinct.
// Ports: code (DIGITS*DIGIT_W packed digits, digit i at [i*DIGIT_W +: DIGIT_W]),
//        valid_c (1 = legal code).
module bc_digit_check #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned BASE    = 10
) (
  input  logic [DIGITS*DIGIT_W-1:0] code,
  output logic                      valid_c
);

  always_comb begin
    valid_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (32'(code[i*DIGIT_W +: DIGIT_W]) >= BASE) valid_c = 1'b0;
      for (int unsigned j = i + 1; j < DIGITS; j++) begin
        if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) valid_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows (1A2B) game engine: loads a secret, validates guesses and
// iteratively scores them one digit per cycle, tracking win/lose.
// Ports: in_clka clock; in_restart sync active-high reset/new game;
//        in_loadtest / in_enter single-cycle load-secret / submit-guess pulses;
//        in_ans code digits; out_Anum/out_Bnum last score; out_state FSM state;
//        out_valid score-updated pulse; out_input_error rejected-code pulse;
//        out_guess_cnt accepted guesses; out_win/out_lose game-end levels.
// Config macro: BC_ATTEMPT_LIMIT_EN enables the MAX_GUESS loss condition.
module bulls_cows_engine
  import bc_pkg::*;
#(
  parameter  int unsigned DIGITS    = 4,
  parameter  int unsigned DIGIT_W   = 4,
  parameter  int unsigned BASE      = 10,
  parameter  int unsigned MAX_GUESS = 8,
  localparam int unsigned CW        = cnt_w(DIGITS),
  localparam int unsigned GW        = cnt_w(MAX_GUESS)
) (
  input  logic                      in_clka,
  input  logic                      in_restart,
  input  logic                      in_loadtest,
  input  logic                      in_enter,
  input  logic [DIGITS*DIGIT_W-1:0] in_ans,
  output logic [CW-1:0]             out_Anum,
  output logic [CW-1:0]             out_Bnum,
  output logic [2:0]                out_state,
  output logic                      out_valid,
  output logic                      out_input_error,
  output logic [GW-1:0]             out_guess_cnt,
  output logic                      out_win,
  output logic                      out_lose
);

  localparam int unsigned N  = DIGITS * DIGIT_W;
  localparam int unsigned IW = $clog2(DIGITS);

  state_t          state;
  logic [N-1:0]    in_reg;
  logic [N-1:0]    secret;
  logic [CW-1:0]   a_acc, b_acc;
  logic [IW-1:0]   idx;
  logic            code_ok;
  logic            lose_q;

  // Single validator serves both secret and guess checks through in_reg.
  bc_digit_check #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W),
    .BASE   (BASE)
  ) u_check (
    .code   (in_reg),
    .valid_c(code_ok)
  );

  // Per-cycle scoring of guess digit idx against the whole secret.
  logic [31:0]        sh;
  logic [DIGIT_W-1:0] g_dig, s_dig;
  logic               hit_a, hit_b;
  logic [CW-1:0]      a_nxt, b_nxt;

  always_comb begin
    sh    = 32'(idx) * DIGIT_W;
    g_dig = DIGIT_W'(in_reg >> sh);
    s_dig = DIGIT_W'(secret >> sh);
    hit_a = (g_dig == s_dig);
    hit_b = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if ((j != 32'(idx)) && (g_dig == secret[j*DIGIT_W +: DIGIT_W])) hit_b = 1'b1;
    end
    a_nxt = a_acc + CW'(hit_a);
    b_nxt = b_acc + CW'(hit_b);
  end

  // Game FSM with registered outputs; score lands on the edge into RESULT.
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state           <= ST_IDLE;
      in_reg          <= '0;
      secret          <= '0;
      a_acc           <= '0;
      b_acc           <= '0;
      idx             <= '0;
      out_Anum        <= '0;
      out_Bnum        <= '0;
      out_valid       <= 1'b0;
      out_input_error <= 1'b0;
      out_guess_cnt   <= '0;
      out_win         <= 1'b0;
      lose_q          <= 1'b0;
    end else begin
      out_valid       <= 1'b0;
      out_input_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_loadtest) begin
            in_reg <= in_ans;
            state  <= ST_CHK_S;
          end
        end
        ST_CHK_S: begin
          if (code_ok) begin
            secret <= in_reg;
            state  <= ST_WAIT;
          end else begin
            out_input_error <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (in_enter) begin
            in_reg <= in_ans;
            state  <= ST_CHK_G;
          end
        end
        ST_CHK_G: begin
          if (code_ok) begin
            a_acc <= '0;
            b_acc <= '0;
            idx   <= '0;
            state <= ST_CMP;
          end else begin
            out_input_error <= 1'b1;
            state           <= ST_WAIT;
          end
        end
        ST_CMP: begin
          a_acc <= a_nxt;
          b_acc <= b_nxt;
          if (idx == IW'(DIGITS - 1)) begin
            out_Anum  <= a_nxt;
            out_Bnum  <= b_nxt;
            out_valid <= 1'b1;
            if (out_guess_cnt != GW'(MAX_GUESS)) out_guess_cnt <= out_guess_cnt + GW'(1);
            state <= ST_RESULT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_RESULT: begin
          if (out_Anum == CW'(DIGITS)) begin
            out_win <= 1'b1;
            state   <= ST_WIN;
          end
`ifdef BC_ATTEMPT_LIMIT_EN
          else if (out_guess_cnt == GW'(MAX_GUESS)) begin
            lose_q <= 1'b1;
            state  <= ST_LOSE;
          end
`endif
          else begin
            state <= ST_WAIT;
          end
        end
        ST_WIN, ST_LOSE: state <= state;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_state = state;

`ifdef BC_ATTEMPT_LIMIT_EN
  assign out_lose = lose_q;
`else
  // No attempt limit: the loss flag can never rise.
  assign out_lose = 1'b0;
`endif

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Scoreboard bench for bulls_cows_engine: a 4-digit base-10 instance with
// MAX_GUESS=2 and a 6-digit base-16 instance.
module tb_bulls_cows_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_err;
    int a;
    int b;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // DUT 0: DIGITS=4, BASE=10, MAX_GUESS=2
  logic        restart0, load0, enter0;
  logic [15:0] ans0;
  logic [2:0]  anum0, bnum0, state0;
  logic        valid0, err0, win0, lose0;
  logic [1:0]  gcnt0;

  // DUT 1: DIGITS=6, BASE=16
  logic        restart1, load1, enter1;
  logic [23:0] ans1;
  logic [2:0]  anum1, bnum1, state1;
  logic        valid1, err1, win1, lose1;
  logic [3:0]  gcnt1;

  bulls_cows_engine #(.DIGITS(4), .DIGIT_W(4), .BASE(10), .MAX_GUESS(2)) dut0 (
    .in_clka(clk), .in_restart(restart0), .in_loadtest(load0), .in_enter(enter0),
    .in_ans(ans0), .out_Anum(anum0), .out_Bnum(bnum0), .out_state(state0),
    .out_valid(valid0), .out_input_error(err0), .out_guess_cnt(gcnt0),
    .out_win(win0), .out_lose(lose0)
  );

  bulls_cows_engine #(.DIGITS(6), .DIGIT_W(4), .BASE(16), .MAX_GUESS(8)) dut1 (
    .in_clka(clk), .in_restart(restart1), .in_loadtest(load1), .in_enter(enter1),
    .in_ans(ans1), .out_Anum(anum1), .out_Bnum(bnum1), .out_state(state1),
    .out_valid(valid1), .out_input_error(err1), .out_guess_cnt(gcnt1),
    .out_win(win1), .out_lose(lose1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a result or an error.
  always @(negedge clk) begin
    if (valid0 === 1'b1 || err0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected: valid=%0b err=%0b, expected no output (cycle %0d)",
                 valid0, err0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_is_err", int'(err0), int'(e.is_err));
        if (!e.is_err) begin
          check("dut0_A", int'(anum0), e.a);
          check("dut0_B", int'(bnum0), e.b);
        end
        check("dut0_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (valid1 === 1'b1 || err1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected: valid=%0b err=%0b, expected no output (cycle %0d)",
                 valid1, err1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_is_err", int'(err1), int'(e.is_err));
        if (!e.is_err) begin
          check("dut1_A", int'(anum1), e.a);
          check("dut1_B", int'(bnum1), e.b);
        end
        check("dut1_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart0_t();
    restart0 = 1'b1;
    tick(1);
    restart0 = 1'b0;
  endtask

  // Secret load; a rejected code expects an error pulse two cycles later.
  task automatic load0_t(input logic [15:0] c, input bit bad);
    exp_t e;
    if (bad) begin
      e = '{is_err: 1'b1, a: 0, b: 0, cyc: cyc + 2};
      q0.push_back(e);
    end
    ans0  = c;
    load0 = 1'b1;
    tick(1);
    load0 = 1'b0;
  endtask

  // Guess submit; valid guesses score at t+2+DIGITS, bad ones error at t+2.
  task automatic enter0_t(input logic [15:0] c, input bit bad, input int a, input int b);
    exp_t e;
    e = '{is_err: bad, a: a, b: b, cyc: bad ? cyc + 2 : cyc + 6};
    q0.push_back(e);
    ans0   = c;
    enter0 = 1'b1;
    tick(1);
    enter0 = 1'b0;
  endtask

  // Pulse that the DUT must ignore (nothing pushed).
  task automatic raw_pulses0(input logic [15:0] c);
    ans0   = c;
    enter0 = 1'b1;
    load0  = 1'b1;
    tick(1);
    enter0 = 1'b0;
    load0  = 1'b0;
  endtask

  initial begin
    exp_t e;
    restart0 = 1'b1; load0 = 1'b0; enter0 = 1'b0; ans0 = '0;
    restart1 = 1'b1; load1 = 1'b0; enter1 = 1'b0; ans1 = '0;
    tick(2);
    restart0 = 1'b0;
    restart1 = 1'b0;

    // Reset state
    check("rst_state", int'(state0), 0);
    check("rst_A", int'(anum0), 0);
    check("rst_B", int'(bnum0), 0);
    check("rst_valid", int'(valid0), 0);
    check("rst_err", int'(err0), 0);
    check("rst_gcnt", int'(gcnt0), 0);
    check("rst_win", int'(win0), 0);
    check("rst_lose", int'(lose0), 0);

    // Load 1234, guess 1243 -> A2 B2
    load0_t(16'h1234, 1'b0);
    tick(1);
    check("load_to_wait", int'(state0), 2);
    enter0_t(16'h1243, 1'b0, 2, 2);
    tick(7);
    check("g1_state", int'(state0), 2);
    check("g1_gcnt", int'(gcnt0), 1);
    check("g1_A_hold", int'(anum0), 2);
    check("g1_B_hold", int'(bnum0), 2);
    // Duplicate digits in a guess: rejected, not counted
    enter0_t(16'h1124, 1'b1, 0, 0);
    tick(3);
    check("bad_guess_state", int'(state0), 2);
    check("bad_guess_gcnt", int'(gcnt0), 1);

    // Illegal secrets
    restart0_t();
    load0_t(16'h1123, 1'b1);
    tick(2);
    check("dup_secret_idle", int'(state0), 0);
    load0_t(16'h9A00, 1'b1);
    tick(2);
    check("range_secret_idle", int'(state0), 0);
    load0_t(16'h12B4, 1'b1);
    tick(2);
    check("range2_secret_idle", int'(state0), 0);

    // Win, then further pulses ignored
    restart0_t();
    load0_t(16'h5678, 1'b0);
    tick(1);
    enter0_t(16'h5678, 1'b0, 4, 0);
    tick(7);
    check("win_flag", int'(win0), 1);
    check("win_state", int'(state0), 6);
    raw_pulses0(16'h1234);
    tick(8);
    check("win_hold_state", int'(state0), 6);
    check("win_hold_gcnt", int'(gcnt0), 1);
    check("win_hold_flag", int'(win0), 1);

    // Attempt limit (MAX_GUESS=2)
    restart0_t();
    check("restart_clears_win", int'(win0), 0);
    load0_t(16'h4567, 1'b0);
    tick(1);
    enter0_t(16'h0123, 1'b0, 0, 0);
    tick(7);
    check("lim1_state", int'(state0), 2);
    check("lim1_gcnt", int'(gcnt0), 1);
    enter0_t(16'h0123, 1'b0, 0, 0);
    tick(7);
`ifdef BC_ATTEMPT_LIMIT_EN
    check("lose_flag", int'(lose0), 1);
    check("lose_state", int'(state0), 7);
    check("lose_gcnt", int'(gcnt0), 2);
    raw_pulses0(16'h4567);
    tick(8);
    check("lose_hold_state", int'(state0), 7);
`else
    check("nolimit_lose", int'(lose0), 0);
    check("nolimit_state", int'(state0), 2);
    check("nolimit_gcnt", int'(gcnt0), 2);
    enter0_t(16'h0123, 1'b0, 0, 0);
    tick(7);
    check("gcnt_saturate", int'(gcnt0), 2);
    check("sat_state", int'(state0), 2);
    check("sat_lose", int'(lose0), 0);
`endif

    // Restart during CMP discards the guess
    restart0_t();
    load0_t(16'h1234, 1'b0);
    tick(1);
    enter0_t(16'h1243, 1'b0, 2, 2);
    tick(7);
    ans0   = 16'h1243;
    enter0 = 1'b1;
    tick(1);
    enter0 = 1'b0;
    tick(2);
    check("in_cmp", int'(state0), 4);
    restart0_t();
    check("midcmp_state", int'(state0), 0);
    check("midcmp_A", int'(anum0), 0);
    check("midcmp_B", int'(bnum0), 0);
    check("midcmp_gcnt", int'(gcnt0), 0);
    check("midcmp_valid", int'(valid0), 0);
    tick(8);

    // 6-digit base-16: ABCDEF vs FEDCBA -> A0 B6 at t+8
    ans1  = 24'hABCDEF;
    load1 = 1'b1;
    tick(1);
    load1 = 1'b0;
    tick(1);
    check("d6_load_wait", int'(state1), 2);
    e = '{is_err: 1'b0, a: 0, b: 6, cyc: cyc + 8};
    q1.push_back(e);
    ans1   = 24'hFEDCBA;
    enter1 = 1'b1;
    tick(1);
    enter1 = 1'b0;
    tick(9);
    check("d6_state", int'(state1), 2);
    check("d6_A", int'(anum1), 0);
    check("d6_B", int'(bnum1), 6);
    check("d6_gcnt", int'(gcnt1), 1);

    tick(2);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
